stream_insert_sorter: RTL and testbench
=======================================

// Module: stream_insert_sorter
// PURPOSE
//  Streaming insertion-sort buffer. It is the consumer stage for the 8-bit words that the
//  SRAM sort controller reads, one per handshake. It keeps up to DEPTH entries, ordered at
//  all times, and exposes them in parallel for write-back. On request it drains them
//  serially, smallest first, through a valid/ready handshake.
// PARAMETERS
//  DW     8  data width of one entry
//  DEPTH  4  number of entries (>=2)
//  CW     3  count width, = $clog2(DEPTH+1)
// PORTS
//  clk          in   1         rising-edge clock, single clock domain
//  reset        in   1         synchronous, active-high reset
//  clear        in   1         synchronous flush: empties the buffer, returns to FILL
//  in_valid     in   1         in_data is valid this cycle
//  in_data      in   DW        word to insert
//  in_ready     out  1         (state==FILL) && !full; combinational
//  drain_start  in   1         request serial readout
//  out_valid    out  1         (state==DRAIN); combinational
//  out_data     out  DW        e[0], the current smallest entry
//  out_ready    in   1         consumer accepts out_data
//  out_last     out  1         out_valid && count==1
//  out_flat     out  DEPTH*DW  {e[DEPTH-1],...,e[0]}; e[0] at bits [DW-1:0]
//  count        out  CW        number of valid entries
//  full         out  1         count==DEPTH
// BEHAVIOUR
//  - Storage e[0..DEPTH-1] is always sorted ascending. Empty slots hold FILL_VAL = all-ones.
//    The slots e[count..DEPTH-1] are the empty ones.
//  - Reset and clear are synchronous. Priority: reset > clear > all other events.
//    Both set: state=FILL, count=0, every e[i]=FILL_VAL.
//    Resulting outputs: in_ready=1, out_valid=0, out_last=0, full=0,
//    out_data=FILL_VAL, out_flat all-ones.
//  - Two states: FILL and DRAIN.
//  - FILL, insert: occurs when in_valid && in_ready.
//    - Insert position p = number of valid entries strictly less than in_data. Equal values
//      are therefore placed after existing equals, so the sort is stable.
//    - e[i] <= e[i-1] for p<i<=count; e[p] <= in_data; count <= count+1.
//    - The whole update happens in one cycle. out_flat, count and full reflect the new entry
//      the cycle after the accept.
//  - FILL, full: in_ready=0. in_valid is ignored and no state changes.
//  - FILL, drain_start with count>0 (after any same-cycle insert is counted): next state is
//    DRAIN. An insert and drain_start in the same cycle both take effect; the drain then
//    includes the new word.
//  - FILL, drain_start with count==0 and no insert that cycle: ignored, state stays FILL.
//  - DRAIN: in_ready=0 and out_valid=1.
//    - On out_ready: e[i] <= e[i+1] for i<DEPTH-1; e[DEPTH-1] <= FILL_VAL; count <= count-1.
//    - If this is the out_last beat, next state is FILL.
//    - Without out_ready, out_data and out_last hold stable.
//    - drain_start is ignored in DRAIN.
//  - clear or reset in DRAIN aborts the drain. Next cycle: out_valid=0 and count=0.
//  - Comparisons are unsigned, DW bits. count never exceeds DEPTH and never goes below 0.
// CONFIGURATION
//  SORT_DESCENDING_EN
//   Defined:
//    - e[0] holds the largest entry, and p counts valid entries strictly greater than
//      in_data.
//    - FILL_VAL = all-zeros, including at reset and clear.
//    - The drain emits largest first.
//   Undefined: ascending behaviour as specified above.
// TESTING
//  1. reset; push 5,3,9,1 (DW=8, DEPTH=4) -> out_flat={9,5,3,1}, count=4, full=1,
//     in_ready=0.
//  2. Full buffer as in 1; in_valid=1 with 7 for 3 cycles -> out_flat and count unchanged.
//  3. drain_start with out_ready=1 held -> out_data 1,3,5,9 on 4 consecutive cycles.
//     out_last=1 only on 9. Next cycle: FILL, count=0, in_ready=1.
//  4. Push 4,4,2, then drain with out_ready toggling 1,0,1,0... -> out_data sequence 2,4,4.
//     Value holds during each out_ready=0 cycle.
//  5. Fill with 5,3,9,1; drain 2 beats; assert clear -> next cycle out_valid=0, count=0,
//     out_flat all-ones, in_ready=1.
//  6. SORT_DESCENDING_EN defined; push 5,3,9,1 -> out_flat={1,3,5,9}; drain emits 9,5,3,1.

Source files
------------

// File: rtl/stream_insert_sorter.sv
// Streaming insertion-sort buffer: keeps DEPTH entries ordered, drains smallest first.
// Build option: define SORT_DESCENDING_EN to keep the largest entry at e[0] instead.
module stream_insert_sorter #(
   parameter int DW    = 8,
   parameter int DEPTH = 4,
   parameter int CW    = $clog2(DEPTH+1)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                clear,
   input  logic                in_valid,
   input  logic [DW-1:0]       in_data,
   output logic                in_ready,
   input  logic                drain_start,
   output logic                out_valid,
   output logic [DW-1:0]       out_data,
   input  logic                out_ready,
   output logic                out_last,
   output logic [DEPTH*DW-1:0] out_flat,
   output logic [CW-1:0]       count,
   output logic                full,
   output logic [0:0]          dbg_state
);

   // Handshakes: a word moves on a port only in a cycle where its valid and ready are
   // both high; valid never depends on ready, and the offered data holds until taken.

   localparam logic [0:0] ST_FILL  = 1'b0;
   localparam logic [0:0] ST_DRAIN = 1'b1;

`ifdef SORT_DESCENDING_EN
   localparam logic [DW-1:0] FILL_VAL = '0;
`else
   localparam logic [DW-1:0] FILL_VAL = '1;
`endif

   logic [0:0]    state_q, state_d;
   logic [CW-1:0] count_q, count_d;
   logic [DW-1:0] e_q [DEPTH];
   logic [DW-1:0] e_d [DEPTH];

   logic          accept;
   logic          pop;
   logic [CW-1:0] ins_pos;
   logic [CW-1:0] count_after_ins;

   assign full      = (count_q == CW'(DEPTH));
   assign in_ready  = (state_q == ST_FILL) && !full;
   assign out_valid = (state_q == ST_DRAIN);
   assign out_data  = e_q[0];
   assign out_last  = out_valid && (count_q == CW'(1));
   assign count     = count_q;
   assign dbg_state = state_q;
   assign accept    = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   always_comb begin
      out_flat = '0;
      for (int i = 0; i < DEPTH; i++) begin
         out_flat[i*DW +: DW] = e_q[i];
      end
   end

   // Insert position: valid entries that must stay ahead of the new word. Equals are
   // not counted, so a new word lands behind any existing equals (stable order).
   always_comb begin
      ins_pos = '0;
      for (int i = 0; i < DEPTH; i++) begin
`ifdef SORT_DESCENDING_EN
         if ((CW'(i) < count_q) && (e_q[i] > in_data)) begin
`else
         if ((CW'(i) < count_q) && (e_q[i] < in_data)) begin
`endif
            ins_pos = ins_pos + CW'(1);
         end
      end
   end

   assign count_after_ins = accept ? (count_q + CW'(1)) : count_q;

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      for (int i = 0; i < DEPTH; i++) begin
         e_d[i] = e_q[i];
      end

      if (clear) begin
         state_d = ST_FILL;
         count_d = '0;
         for (int i = 0; i < DEPTH; i++) begin
            e_d[i] = FILL_VAL;
         end
      end else if (state_q == ST_FILL) begin
         if (accept) begin
            if (ins_pos == '0) begin
               e_d[0] = in_data;
            end
            for (int i = 1; i < DEPTH; i++) begin
               if (CW'(i) == ins_pos) begin
                  e_d[i] = in_data;
               end else if ((CW'(i) > ins_pos) && (CW'(i) <= count_q)) begin
                  e_d[i] = e_q[i-1];
               end
            end
            count_d = count_after_ins;
         end
         if (drain_start && (count_after_ins != '0)) begin
            state_d = ST_DRAIN;
         end
      end else begin
         if (pop) begin
            for (int i = 0; i < DEPTH-1; i++) begin
               e_d[i] = e_q[i+1];
            end
            e_d[DEPTH-1] = FILL_VAL;
            if (count_q != '0) begin
               count_d = count_q - CW'(1);
            end
            if (count_q <= CW'(1)) begin
               state_d = ST_FILL;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_FILL;
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            e_q[i] <= FILL_VAL;
         end
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         for (int i = 0; i < DEPTH; i++) begin
            e_q[i] <= e_d[i];
         end
      end
   end

endmodule

// File: tb/tb_stream_insert_sorter.sv
// Directed bench for stream_insert_sorter (DW=8, DEPTH=4); drained words are
// checked against an expected queue. Define SORT_DESCENDING_EN for the descending build.
module tb_stream_insert_sorter;

   localparam int DW    = 8;
   localparam int DEPTH = 4;
   localparam int CW    = 3;

   logic                clk = 1'b0;
   logic                reset;
   logic                clear;
   logic                in_valid;
   logic [DW-1:0]       in_data;
   logic                in_ready;
   logic                drain_start;
   logic                out_valid;
   logic [DW-1:0]       out_data;
   logic                out_ready;
   logic                out_last;
   logic [DEPTH*DW-1:0] out_flat;
   logic [CW-1:0]       count;
   logic                full;
   logic [0:0]          dbg_state;

   int checks = 0;
   int errors = 0;
   logic [DW-1:0] exp_q[$];

   stream_insert_sorter #(.DW(DW), .DEPTH(DEPTH), .CW(CW)) dut (
      .clk(clk), .reset(reset), .clear(clear),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .drain_start(drain_start),
      .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
      .out_last(out_last), .out_flat(out_flat), .count(count), .full(full),
      .dbg_state(dbg_state)
   );

   // clock / reset
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [DW-1:0] v);
      int n = 0;
      while (!in_ready && n < 10) begin
         step();
         n++;
      end
      check("push_ready", in_ready, 1);
      in_valid = 1'b1;
      in_data  = v;
      step();
      in_valid = 1'b0;
   endtask

   task automatic start_drain();
      drain_start = 1'b1;
      step();
      drain_start = 1'b0;
   endtask

   // drain with a given out_ready pattern; checks each beat against exp_q
   task automatic drain_all(input bit toggle);
      int cyc = 0;
      logic rdy;
      while (exp_q.size() > 0 && cyc < 40) begin
         rdy = toggle ? ((cyc % 2) == 0) : 1'b1;
         out_ready = rdy;
         check("drain_valid", out_valid, 1);
         check("drain_data", out_data, exp_q[0]);
         check("drain_last", out_last, (exp_q.size() == 1));
         if (rdy) void'(exp_q.pop_front());
         step();
         cyc++;
      end
      out_ready = 1'b0;
      check("drain_budget", (exp_q.size() == 0), 1);
      exp_q.delete();
   endtask

   initial begin
      reset = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = '0;
      drain_start = 1'b0; out_ready = 1'b0;
      step(); step();
      reset = 1'b0;
      step();

`ifdef SORT_DESCENDING_EN
      check("rst_out_data", out_data, 8'h00);
      check("rst_flat", out_flat, 32'h0000_0000);
      check("rst_in_ready", in_ready, 1);
      check("rst_count", count, 0);
      push(8'd5); push(8'd3); push(8'd9); push(8'd1);
      check("desc_flat", out_flat, 32'h0103_0509);
      check("desc_full", full, 1);
      exp_q = '{8'd9, 8'd5, 8'd3, 8'd1};
      out_ready = 1'b1;
      start_drain();
      drain_all(1'b0);
      check("desc_end_valid", out_valid, 0);
      check("desc_end_count", count, 0);
      check("desc_end_flat", out_flat, 32'h0000_0000);
`else
      // reset state
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_last", out_last, 0);
      check("rst_full", full, 0);
      check("rst_count", count, 0);
      check("rst_out_data", out_data, 8'hff);
      check("rst_flat", out_flat, 32'hffff_ffff);
      check("rst_state", dbg_state, 0);

      // fill 5,3,9,1
      push(8'd5);
      check("one_flat", out_flat, 32'hffff_ff05);
      check("one_count", count, 1);
      push(8'd3); push(8'd9); push(8'd1);
      check("fill_flat", out_flat, 32'h0905_0301);
      check("fill_count", count, 4);
      check("fill_full", full, 1);
      check("fill_in_ready", in_ready, 0);

      // full: pushes ignored
      in_valid = 1'b1; in_data = 8'd7;
      for (int k = 0; k < 3; k++) begin
         step();
         check("full_flat", out_flat, 32'h0905_0301);
         check("full_count", count, 4);
      end
      in_valid = 1'b0;

      // drain with ready held high
      exp_q = '{8'd1, 8'd3, 8'd5, 8'd9};
      out_ready = 1'b1;
      start_drain();
      drain_all(1'b0);
      check("d1_valid", out_valid, 0);
      check("d1_count", count, 0);
      check("d1_in_ready", in_ready, 1);
      check("d1_flat", out_flat, 32'hffff_ffff);

      // drain_start on empty is ignored
      start_drain();
      check("empty_drain", out_valid, 0);

      // duplicates, toggling ready
      push(8'd4); push(8'd4); push(8'd2);
      check("dup_flat", out_flat, 32'hff04_0402);
      check("dup_count", count, 3);
      exp_q = '{8'd2, 8'd4, 8'd4};
      start_drain();
      drain_all(1'b1);
      check("d2_valid", out_valid, 0);

      // insert and drain_start in the same cycle
      in_valid = 1'b1; in_data = 8'd6; drain_start = 1'b1;
      step();
      in_valid = 1'b0; drain_start = 1'b0;
      check("same_valid", out_valid, 1);
      check("same_data", out_data, 8'd6);
      check("same_last", out_last, 1);
      check("same_in_ready", in_ready, 0);
      exp_q = '{8'd6};
      drain_all(1'b0);

      // clear aborts a drain
      push(8'd5); push(8'd3); push(8'd9); push(8'd1);
      out_ready = 1'b1;
      start_drain();
      step(); step();
      out_ready = 1'b0;
      check("abort_mid_data", out_data, 8'd5);
      check("abort_mid_count", count, 2);
      clear = 1'b1;
      step();
      clear = 1'b0;
      check("clr_valid", out_valid, 0);
      check("clr_count", count, 0);
      check("clr_flat", out_flat, 32'hffff_ffff);
      check("clr_in_ready", in_ready, 1);
      check("clr_out_data", out_data, 8'hff);

      // reset beats clear and a pending insert
      push(8'd8);
      in_valid = 1'b1; in_data = 8'd1; clear = 1'b1; reset = 1'b1;
      step();
      in_valid = 1'b0; clear = 1'b0; reset = 1'b0;
      check("rst2_count", count, 0);
      check("rst2_flat", out_flat, 32'hffff_ffff);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
